axis_pkt_framer: RTL
====================

Name: axis_pkt_framer

Overview:
Store-and-forward packet framer that sits directly downstream of axis_snoop_arb and consumes its arbitrated AXI-Stream master output. It buffers one complete packet, then re-emits it prefixed by a 2-beat header: a start-of-frame marker followed by the payload byte count. Oversized packets are discarded whole and counted, so downstream logic only ever sees well-formed, length-tagged frames.

Parameters:
PORT_WIDTH, 8, data width; must be 8. The length byte encodes payload count directly.
MAX_LEN, 16, maximum accepted payload beats; legal range 1..255; sets buffer depth.
SOF_BYTE, 8'hA5, value of header beat 0.

Ports:
axis_aclk  in  1  clock; all logic on the rising edge.
axis_areset  in  1  synchronous, active-high reset.
s_axis_tdata  in  PORT_WIDTH  payload from the arbiter.
s_axis_tlast  in  1  last payload beat.
s_axis_tvalid  in  1  input beat valid.
s_axis_tready  out  1  framer can accept a beat.
m_axis_tdata  out  PORT_WIDTH  framed output data.
m_axis_tlast  out  1  last beat of the framed output.
m_axis_tvalid  out  1  output beat valid.
m_axis_tready  in  1  downstream ready.
pkt_count  out  16  frames fully emitted; saturates at 16'hFFFF.
drop_count  out  16  packets discarded as oversized; saturates at 16'hFFFF.

Behaviour:
- Clocking and reset: one clock, axis_aclk. axis_areset is synchronous and active-high.
- On reset:
  - state=FILL, byte count=0.
  - s_axis_tready=1, m_axis_tvalid=0, m_axis_tlast=0, m_axis_tdata=0.
  - pkt_count=0, drop_count=0.
- Reset mid-operation discards any partial or pending frame. No output beat is driven in the cycle after reset.
- Handshake: a transfer occurs on an edge where valid&&ready.
  - m_axis_tdata, m_axis_tvalid and m_axis_tlast hold stable while tvalid=1 and tready=0.
  - m_axis_tvalid never depends combinationally on m_axis_tready.
- State FILL:
  - s_axis_tready=1, m_axis_tvalid=0.
  - Each accepted beat is written to buffer[cnt] and cnt increments.
  - If the accepted beat is beat number MAX_LEN+1 (cnt==MAX_LEN at accept): the beat is not stored.
    - tlast=0 on that beat -> DROP.
    - tlast=1 on that beat -> drop_count++, cnt=0, stay FILL.
  - Else if tlast=1 -> latch len=cnt+1, go to HDR0.
- State DROP:
  - s_axis_tready=1; beats are discarded.
  - On the accepted tlast beat: drop_count++, cnt=0 -> FILL.
- State HDR0:
  - s_axis_tready=0, m_axis_tvalid=1, tdata=SOF_BYTE, tlast=0.
  - On transfer -> HDR1.
- State HDR1:
  - tdata=len, tlast=0.
  - On transfer -> DRAIN with read pointer rd=0.
- State DRAIN:
  - tdata=buffer[rd], tlast=(rd==len-1).
  - On transfer rd increments.
  - On the transfer with tlast: pkt_count++, cnt=0 -> FILL.
- Latency: tlast accepted at edge N puts SOF on the output (m_axis_tvalid=1) after edge N. With m_axis_tready held at 1, a payload of L beats completes in L+2 cycles.
- Throughput: input is stalled (s_axis_tready=0) during HDR0, HDR1 and DRAIN. The upstream arbiter FIFOs absorb this stall.
- Boundary conditions:
  - A 1-beat packet gives len=1; the output is SOF, 8'h01, data with tlast on the data beat.
  - A MAX_LEN-beat packet is accepted (len=MAX_LEN).
  - A packet of MAX_LEN+1 or more beats is dropped.
  - Input with tvalid=0 in FILL leaves all state unchanged.
  - Buffer contents are never cleared; only beats below len are read.
- Counters: both increment by exactly 1 per event and stick at 16'hFFFF.

Test Plan:
- Reset then 3-beat packet A0,A1,A2 with m_axis_tready=1 -> output A5,03,A0,A1,A2 on consecutive cycles; tlast only on A2; pkt_count=1.
- Two back-to-back packets B0..B3 then C0,C1 (upstream held by s_axis_tready=0 during framing) -> A5,04,B0,B1,B2,B3 then A5,02,C0,C1; pkt_count=2; no beat lost or reordered.
- Packet D0,D1,D2 with m_axis_tready dropped for 5 cycles after the header length beat -> D0 held stable on m_axis_tdata with tvalid=1 throughout the stall; stream resumes intact.
- 17-beat packet (MAX_LEN=16), then 16-beat packet 00..0F -> first packet produces no output and drop_count=1; second emits A5,10,00..0F with pkt_count=1.
- Single-beat packet E7 -> A5,01,E7 with tlast on E7.
- Assert axis_areset during DRAIN of a 4-beat packet -> next cycle m_axis_tvalid=0, s_axis_tready=1, counters 0; a following packet F0 frames correctly as A5,01,F0.

Source files
------------

// File: rtl/axis_pkt_framer.sv
// Store-and-forward AXI-Stream framer: buffers one packet, then emits SOF, length, payload.
// Oversized packets are dropped whole and counted.
module axis_pkt_framer #(
    parameter int          PORT_WIDTH = 8,
    parameter int          MAX_LEN    = 16,
    parameter logic [7:0]  SOF_BYTE   = 8'hA5
) (
    input  logic                  axis_aclk,
    input  logic                  axis_areset,
    input  logic [PORT_WIDTH-1:0] s_axis_tdata,
    input  logic                  s_axis_tlast,
    input  logic                  s_axis_tvalid,
    output logic                  s_axis_tready,
    output logic [PORT_WIDTH-1:0] m_axis_tdata,
    output logic                  m_axis_tlast,
    output logic                  m_axis_tvalid,
    input  logic                  m_axis_tready,
    output logic [15:0]           pkt_count,
    output logic [15:0]           drop_count
);

    localparam int         AW      = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
    localparam logic [7:0] MAX_CNT = 8'(MAX_LEN);

    localparam logic [2:0] ST_FILL  = 3'd0;
    localparam logic [2:0] ST_DROP  = 3'd1;
    localparam logic [2:0] ST_HDR0  = 3'd2;
    localparam logic [2:0] ST_HDR1  = 3'd3;
    localparam logic [2:0] ST_DRAIN = 3'd4;

    logic [2:0]            state;
    logic [7:0]            cnt;
    logic [7:0]            len;
    logic [7:0]            rd;
    logic [PORT_WIDTH-1:0] buffer [MAX_LEN];

    logic s_fire;
    logic m_fire;
    logic full_beat;

    assign s_axis_tready = (state == ST_FILL) || (state == ST_DROP);
    assign s_fire        = s_axis_tvalid && s_axis_tready;
    assign m_fire        = m_axis_tvalid && m_axis_tready;
    // Beat MAX_LEN+1 of a packet: never stored, it marks the packet oversized.
    assign full_beat     = (cnt == MAX_CNT);

    // Outputs decode from registered state only, so they hold through back-pressure
    // and tvalid has no combinational path from m_axis_tready.
    always_comb begin
        m_axis_tvalid = 1'b0;
        m_axis_tlast  = 1'b0;
        m_axis_tdata  = '0;
        case (state)
            ST_HDR0: begin
                m_axis_tvalid = 1'b1;
                m_axis_tdata  = PORT_WIDTH'(SOF_BYTE);
            end
            ST_HDR1: begin
                m_axis_tvalid = 1'b1;
                m_axis_tdata  = PORT_WIDTH'(len);
            end
            ST_DRAIN: begin
                m_axis_tvalid = 1'b1;
                m_axis_tdata  = buffer[rd[AW-1:0]];
                m_axis_tlast  = (rd == len - 8'd1);
            end
            default: ;
        endcase
    end

    // NOTE: the packet buffer has no reset; stale entries are never read because
    // only indices below len are drained, and leaving it unreset keeps it in RAM.
    always_ff @(posedge axis_aclk) begin
        if (state == ST_FILL && s_fire && !full_beat)
            buffer[cnt[AW-1:0]] <= s_axis_tdata;
    end

    always_ff @(posedge axis_aclk) begin
        if (axis_areset) begin
            state      <= ST_FILL;
            cnt        <= '0;
            len        <= '0;
            rd         <= '0;
            pkt_count  <= '0;
            drop_count <= '0;
        end else begin
            case (state)
                ST_FILL: begin
                    if (s_fire) begin
                        if (full_beat) begin
                            if (s_axis_tlast) begin
                                if (drop_count != 16'hFFFF) drop_count <= drop_count + 16'd1;
                                cnt <= '0;
                            end else begin
                                state <= ST_DROP;
                            end
                        end else if (s_axis_tlast) begin
                            len   <= cnt + 8'd1;
                            state <= ST_HDR0;
                        end else begin
                            cnt <= cnt + 8'd1;
                        end
                    end
                end
                ST_DROP: begin
                    if (s_fire && s_axis_tlast) begin
                        if (drop_count != 16'hFFFF) drop_count <= drop_count + 16'd1;
                        cnt   <= '0;
                        state <= ST_FILL;
                    end
                end
                ST_HDR0: begin
                    if (m_fire) state <= ST_HDR1;
                end
                ST_HDR1: begin
                    if (m_fire) begin
                        rd    <= '0;
                        state <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    if (m_fire) begin
                        rd <= rd + 8'd1;
                        if (m_axis_tlast) begin
                            if (pkt_count != 16'hFFFF) pkt_count <= pkt_count + 16'd1;
                            cnt   <= '0;
                            state <= ST_FILL;
                        end
                    end
                end
                default: state <= ST_FILL;
            endcase
        end
    end

endmodule
